imsic_msi_arbiter: RTL and testbench
====================================

Name: imsic_msi_arbiter

Overview:
- Shares the single IMSIC MSI write port between NR_REQ MSI producers, e.g. APLIC M-domain and S-domain MSI generators.
- Grants round-robin and latches one request at a time.
- Issues one single-beat MSI write (interrupt file index + EIID) and waits for the write response before the next grant.
- Drops malformed requests and reports completion errors per requester.

Parameters:
NR_REQ, 2, number of MSI requesters (≥1)
NR_INTP_FILES, 3, IMSIC interrupt files (M, S, VS0..)
NR_SRC, 32, interrupt identities; EIID width = NR_SRC_LEN = $clog2(NR_SRC)
FILE_LEN, $clog2(NR_INTP_FILES), file index width
REQ_LEN, $clog2(NR_REQ) (min 1), requester id width
TIMEOUT_CYCLES, 256, response timeout (only with MSI_ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
ni_rst  in  1  asynchronous active-low reset
i_req_valid  in  NR_REQ  per-requester MSI request
o_req_ready  out  NR_REQ  one-hot accept pulse
i_req_file  in  NR_REQ x FILE_LEN  target interrupt file
i_req_eiid  in  NR_REQ x NR_SRC_LEN  identity to set pending
o_msi_valid  out  1  MSI write valid to IMSIC
i_msi_ready  in  1  IMSIC accepts write
o_msi_file  out  FILE_LEN  latched file index
o_msi_eiid  out  NR_SRC_LEN  latched EIID
i_msi_done  in  1  write response
i_msi_err  in  1  response error, qualified by i_msi_done
o_err_valid  out  1  one-cycle error pulse
o_err_id  out  REQ_LEN  requester owning the error
o_busy  out  1  FSM not IDLE

Behaviour:
- Interface fixed: one clock i_clk; ni_rst asynchronous, active-low.
- Reset values:
  - all outputs 0
  - FSM=IDLE
  - round-robin pointer=0, so requester 0 has highest priority first
  - latched file/eiid/id = 0
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Grant goes to the first valid requester searching from ptr, ptr+1 … mod NR_REQ.
  - o_req_ready[g]=1 combinationally in the same cycle; latch file, eiid and id.
  - ptr <= g+1 mod NR_REQ.
  - Valid file (< NR_INTP_FILES) → ISSUE.
  - Invalid file → accept, o_err_valid pulse next cycle with o_err_id=g, stay IDLE (no MSI issued).
- ISSUE:
  - o_msi_valid=1 with stable file/eiid until i_msi_ready.
  - Handshake cycle → WAIT_RESP.
  - Done is not accepted in ISSUE.
- WAIT_RESP:
  - On i_msi_done → IDLE.
  - If i_msi_err also high → o_err_valid=1 next cycle, o_err_id=latched id.
- Latency:
  - Request accepted cycle 0 → o_msi_valid cycle 1.
  - Done cycle k → IDLE cycle k+1, next grant cycle k+1.
  - Peak throughput is one MSI per 3 cycles.
- Other rules:
  - o_req_ready is never high outside IDLE; requesters hold valid and payload until ready.
  - A requester deasserting valid before grant is allowed and loses nothing.
  - With all NR_REQ continuously valid, each requester is granted exactly once per NR_REQ grants.
  - Simultaneous done+err in the same cycle as a new request: request is granted only in the following IDLE cycle.
  - o_busy = (state != IDLE).
- Reset mid-operation: any in-flight MSI is abandoned, FSM → IDLE, no error reported.

Optional Feature:
- Macro: MSI_ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering WAIT_RESP, increments each WAIT_RESP cycle.
  - Reaching TIMEOUT_CYCLES-1 without done → IDLE and o_err_valid pulse with latched id.
  - A late i_msi_done arriving in IDLE is ignored.
- Undefined: no counter; WAIT_RESP waits indefinitely.

Decomposition:
- Package imsic_msi_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT_RESP)
  - msi_req_t struct {file, eiid}
  - default TIMEOUT_CYCLES constant
- One sub-module, msi_rr_arbiter: parameterised NR_REQ round-robin priority pick.
  - Inputs: valid vector, ptr, enable.
  - Outputs: one-hot grant, encoded index, any_grant.

Test Plan:
- Reset with i_req_valid=2'b11 held low → all outputs 0; after release, req0 granted at cycle 0 and o_msi_valid=1 at cycle 1 with req0 file/eiid.
- Both requesters valid continuously, i_msi_ready=1, done 1 cycle after issue → grants alternate 0,1,0,1; o_msi_eiid sequence matches; no error pulses.
- req1 with file=3 (NR_INTP_FILES=3), eiid=5 → o_req_ready[1]=1, o_msi_valid stays 0, o_err_valid=1 next cycle with o_err_id=1.
- i_msi_ready held low 10 cycles → o_msi_valid, file and eiid remain stable, o_req_ready=0, o_busy=1 throughout.
- i_msi_done=1 with i_msi_err=1 for req0 transfer → o_err_valid=1 for one cycle, o_err_id=0, FSM back to IDLE.
- With MSI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done → return to IDLE after 8 WAIT_RESP cycles with o_err_valid=1; ni_rst asserted mid-ISSUE → o_msi_valid=0 immediately.

Source files
------------

// File: rtl/imsic_msi_arb_pkg.sv
// imsic_msi_arb_pkg: shared types and defaults for the IMSIC MSI write-port arbiter
package imsic_msi_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_e;

   localparam int DEF_NR_INTP_FILES  = 3;
   localparam int DEF_NR_SRC         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MSI_FILE_LEN = clog2_min1(DEF_NR_INTP_FILES);
   localparam int MSI_EIID_LEN = clog2_min1(DEF_NR_SRC);

   typedef struct packed {
      logic [MSI_FILE_LEN-1:0] file;
      logic [MSI_EIID_LEN-1:0] eiid;
   } msi_req_t;

endpackage

// File: rtl/msi_rr_arbiter.sv
// msi_rr_arbiter: round-robin pick of the first valid requester at or after ptr
module msi_rr_arbiter
   import imsic_msi_arb_pkg::*;
#(
   parameter int NR_REQ  = 2,
   parameter int REQ_LEN = clog2_min1(NR_REQ)
) (
   input  logic               en,
   input  logic [NR_REQ-1:0]  valid,
   input  logic [REQ_LEN-1:0] ptr,
   output logic [NR_REQ-1:0]  gnt,
   output logic [REQ_LEN-1:0] idx,
   output logic               any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NR_REQ; i++) begin
         if (en && !any && valid[(int'(ptr) + i) % NR_REQ]) begin
            any = 1'b1;
            idx = REQ_LEN'((int'(ptr) + i) % NR_REQ);
            gnt[(int'(ptr) + i) % NR_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// imsic_msi_arbiter: shares one IMSIC MSI write port between NR_REQ producers
module imsic_msi_arbiter
  import imsic_msi_arb_pkg::*;
#(
  parameter int NR_REQ         = 2,
  parameter int NR_INTP_FILES  = DEF_NR_INTP_FILES,
  parameter int NR_SRC         = DEF_NR_SRC,
  parameter int FILE_LEN       = clog2_min1(NR_INTP_FILES),
  parameter int NR_SRC_LEN     = clog2_min1(NR_SRC),
  parameter int REQ_LEN        = clog2_min1(NR_REQ),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              i_clk,
  input  logic                              ni_rst,
  input  logic [NR_REQ-1:0]                 i_req_valid,
  output logic [NR_REQ-1:0]                 o_req_ready,
  input  logic [NR_REQ-1:0][FILE_LEN-1:0]   i_req_file,
  input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0] i_req_eiid,
  output logic                              o_msi_valid,
  input  logic                              i_msi_ready,
  output logic [FILE_LEN-1:0]               o_msi_file,
  output logic [NR_SRC_LEN-1:0]             o_msi_eiid,
  input  logic                              i_msi_done,
  input  logic                              i_msi_err,
  output logic                              o_err_valid,
  output logic [REQ_LEN-1:0]                o_err_id,
  output logic                              o_busy
);
  arb_state_e         state, state_nxt;
  logic [REQ_LEN-1:0] ptr, idx, lat_id, err_id;
  logic [NR_REQ-1:0]  gnt;
  logic               any, file_ok, timeout, err_nxt, err_valid;
  msi_req_t           lat;
  msi_rr_arbiter #(.NR_REQ(NR_REQ), .REQ_LEN(REQ_LEN)) u_rr (
    .en    (state == IDLE && ni_rst),
    .valid (i_req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );
  assign file_ok = 32'(i_req_file[idx]) < NR_INTP_FILES;
`ifdef MSI_ARB_TIMEOUT_EN
  localparam int CNT_LEN = clog2_min1(TIMEOUT_CYCLES);
  logic [CNT_LEN-1:0] cnt;
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) cnt <= '0;
    else         cnt <= (state == WAIT_RESP) ? cnt + 1'b1 : '0;
  end
  assign timeout = (state == WAIT_RESP) && !i_msi_done && (cnt == CNT_LEN'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nxt = (state == IDLE)      ? ((any && file_ok) ? ISSUE : IDLE) :
                (state == ISSUE)     ? (i_msi_ready ? WAIT_RESP : ISSUE) :
                (state == WAIT_RESP) ? ((i_msi_done || timeout) ? IDLE : WAIT_RESP) : IDLE;
    err_nxt = (state == IDLE && any && !file_ok) ||
              (state == WAIT_RESP && ((i_msi_done && i_msi_err) || timeout));
  end
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lat       <= '0;
      lat_id    <= '0;
      err_valid <= 1'b0;
      err_id    <= '0;
    end else begin
      state     <= state_nxt;
      err_valid <= err_nxt;
      if (err_nxt) err_id <= (state == IDLE) ? idx : lat_id;
      if (any) begin
        lat.file <= MSI_FILE_LEN'(i_req_file[idx]);
        lat.eiid <= MSI_EIID_LEN'(i_req_eiid[idx]);
        lat_id   <= idx;
        ptr      <= (idx == REQ_LEN'(NR_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  assign o_req_ready = gnt;
  assign o_msi_valid = (state == ISSUE);
  assign o_msi_file  = FILE_LEN'(lat.file);
  assign o_msi_eiid  = NR_SRC_LEN'(lat.eiid);
  assign o_err_valid = err_valid;
  assign o_err_id    = err_id;
  assign o_busy      = (state != IDLE);
endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// tb_imsic_msi_arbiter: scoreboard bench for imsic_msi_arbiter
module tb_imsic_msi_arbiter;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_file = '0;
  logic [1:0][4:0] req_eiid = '0;
  logic            msi_valid;
  logic            msi_ready = 1'b0;
  logic [1:0]      msi_file;
  logic [4:0]      msi_eiid;
  logic            msi_done = 1'b0;
  logic            msi_err = 1'b0;
  logic            err_valid;
  logic [0:0]      err_id;
  logic            busy;
  int checks = 0;
  int errors = 0;
  logic ready_en = 1'b1;
  logic resp_auto = 1'b1;
  logic resp_err = 1'b0;
  logic [6:0]  req_q0[$];
  logic [6:0]  req_q1[$];
  logic [31:0] exp_gnt[$];
  logic [31:0] exp_msi[$];
  logic [31:0] exp_err[$];
  always #5 clk = ~clk;
  imsic_msi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk       (clk),
    .ni_rst      (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_file  (req_file),
    .i_req_eiid  (req_eiid),
    .o_msi_valid (msi_valid),
    .i_msi_ready (msi_ready),
    .o_msi_file  (msi_file),
    .o_msi_eiid  (msi_eiid),
    .i_msi_done  (msi_done),
    .i_msi_err   (msi_err),
    .o_err_valid (err_valid),
    .o_err_id    (err_id),
    .o_busy      (busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    logic [1:0] g;
    forever begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      if (g[0] && req_q0.size() != 0) void'(req_q0.pop_front());
      if (g[1] && req_q1.size() != 0) void'(req_q1.pop_front());
      req_valid[0] = req_q0.size() != 0;
      req_valid[1] = req_q1.size() != 0;
      if (req_valid[0]) {req_file[0], req_eiid[0]} = req_q0[0];
      if (req_valid[1]) {req_file[1], req_eiid[1]} = req_q1[0];
    end
  end
  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = msi_valid && msi_ready && rst_n;
      @(posedge clk);
      #1;
      msi_ready = ready_en;
      msi_done  = hs && resp_auto;
      msi_err   = hs && resp_auto && resp_err;
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (req_ready != 2'b00) begin
        e = 32'hFF;
        if (exp_gnt.size() != 0) e = exp_gnt.pop_front();
        check("grant", 32'(req_ready), e);
      end
      if (msi_valid && msi_ready) begin
        e = 32'hFFFF;
        if (exp_msi.size() != 0) e = exp_msi.pop_front();
        check("msi", 32'({msi_file, msi_eiid}), e);
      end
      if (err_valid) begin
        e = 32'hFF;
        if (exp_err.size() != 0) e = exp_err.pop_front();
        check("err_id", 32'(err_id), e);
        check("err_idle", 32'(busy), 0);
      end
    end
  end
  task automatic push_req(input int r, input logic [1:0] f, input logic [4:0] id, input bit ok);
    if (r == 0) req_q0.push_back({f, id});
    else        req_q1.push_back({f, id});
    exp_gnt.push_back(32'(1 << r));
    if (ok) exp_msi.push_back(32'({f, id}));
    else    exp_err.push_back(32'(r));
  endtask
  task automatic drain(input string tag, input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      done = exp_gnt.size() == 0 && exp_msi.size() == 0 && exp_err.size() == 0 &&
             req_q0.size() == 0 && req_q1.size() == 0 && !busy;
    end
    @(negedge clk);
    check(tag, 32'(exp_gnt.size() + exp_msi.size() + exp_err.size()), 0);
  endtask
  task automatic wait_msi(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (msi_valid) break;
    end
    check(tag, 32'(msi_valid), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    push_req(0, 2'd0, 5'd7, 1);
    push_req(1, 2'd1, 5'd9, 1);
    push_req(0, 2'd2, 5'd11, 1);
    push_req(1, 2'd0, 5'd20, 1);
    repeat (3) @(negedge clk);
    check("reset_out", 32'({req_ready, msi_valid, msi_file, msi_eiid, err_valid, err_id, busy}), 0);
    check("reset_valid", 32'(req_valid), 32'h3);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("first_msi", 32'({msi_valid, msi_file, msi_eiid}), 32'({1'b1, 2'd0, 5'd7}));
    drain("alternate", 60);
    push_req(1, 2'd3, 5'd5, 0);
    @(negedge clk);
    check("bad_file_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("bad_file_no_msi", 32'({msi_valid, busy, err_valid}), 32'h1);
    drain("bad_file", 20);
    push_req(0, 2'd1, 5'd3, 1);
    push_req(1, 2'd2, 5'd4, 1);
    drain("after_bad", 30);
    ready_en = 1'b0;
    push_req(0, 2'd2, 5'd17, 1);
    wait_msi("stall_up", 20);
    push_req(1, 2'd1, 5'd30, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall", 32'({msi_valid, msi_file, msi_eiid, req_ready, busy}),
            32'({1'b1, 2'd2, 5'd17, 2'b00, 1'b1}));
    end
    ready_en = 1'b1;
    drain("stall_release", 30);
    resp_err = 1'b1;
    push_req(0, 2'd0, 5'd1, 1);
    exp_err.push_back(32'd0);
    drain("resp_err", 20);
    resp_err = 1'b0;
    ready_en = 1'b0;
    req_q0.push_back({2'd1, 5'd2});
    exp_gnt.push_back(32'h1);
    wait_msi("rst_issue_up", 20);
    rst_n = 1'b0;
    #1 check("rst_mid", 32'({msi_valid, busy, err_valid, req_ready}), 0);
    ready_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain("rst_quiet", 10);
`ifdef MSI_ARB_TIMEOUT_EN
    begin
      bit hs = 0;
      int n = 0;
      resp_auto = 1'b0;
      push_req(1, 2'd2, 5'd6, 1);
      exp_err.push_back(32'd1);
      for (int i = 0; i < 20 && !hs; i++) begin
        @(negedge clk);
        hs = msi_valid && msi_ready;
      end
      check("to_hs", 32'(hs), 1);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      check("to_cycles", 32'(n), 8);
      drain("timeout", 20);
      resp_auto = 1'b1;
    end
`endif
    check("final_queues", 32'(req_q0.size() + req_q1.size() + exp_gnt.size() + exp_msi.size() + exp_err.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
